// File: rtl/branch_mask_allocator_pkg.sv
// Shared types and constants for the branch-mask allocator and its consumers
// (dispatch, reservation stations, ROB flush logic).
package branch_mask_allocator_pkg;

  localparam int B_MASK_WIDTH   = 4;
  localparam int DISPATCH_WIDTH = 2;
  localparam int BMASK_FREE_CNT = $clog2(B_MASK_WIDTH + 1);
  localparam int BMASK_PERF_W   = 32;

  typedef logic [B_MASK_WIDTH-1:0] B_MASK;

  // What a dispatch slot receives when it asks for a branch tag.
  typedef struct packed {
    logic  valid;
    B_MASK bmm;
    B_MASK dep_mask;
  } BMASK_GRANT_PACKET;

endpackage

// File: rtl/bmask_free_picker.sv
// Finds the lowest NUM_PICKS set bits of free_bits, lowest index first.
// pick_onehot[j] is the j-th free bit (one-hot), pick_found[j] says it exists.
module bmask_free_picker #(
  parameter int NUM_BITS  = 4,
  parameter int NUM_PICKS = 2
) (
  input  logic [NUM_BITS-1:0]                 free_bits,
  output logic [NUM_PICKS-1:0][NUM_BITS-1:0]  pick_onehot,
  output logic [NUM_PICKS-1:0]                pick_found
);

  logic [NUM_BITS-1:0] remaining;

  // successive lowest-set-bit extraction, each pick removed before the next
  always_comb begin
    remaining   = free_bits;
    pick_onehot = '0;
    pick_found  = '0;
    for (int j = 0; j < NUM_PICKS; j++) begin
      for (int i = 0; i < NUM_BITS; i++) begin
        if (remaining[i] && !pick_found[j]) begin
          pick_onehot[j][i] = 1'b1;
          pick_found[j]     = 1'b1;
        end
      end
      remaining = remaining & ~pick_onehot[j];
    end
  end

endmodule

// File: rtl/branch_mask_allocator.sv
// Branch-mask allocator: hands out branch-stack bits in order at dispatch,
// tracks each outstanding branch's dependency mask, frees bits on correct
// resolve and squashes the mispredicted bit plus all dependents on mispredict.
// Optional macro BMASK_ALLOC_PERF_EN adds saturating stall/squash counters.
module branch_mask_allocator #(
  parameter int B_MASK_WIDTH   = branch_mask_allocator_pkg::B_MASK_WIDTH,
  parameter int DISPATCH_WIDTH = branch_mask_allocator_pkg::DISPATCH_WIDTH
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [DISPATCH_WIDTH-1:0]                    dispatch_req,
  output logic [DISPATCH_WIDTH-1:0]                    dispatch_grant,
  output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  grant_bmm,
  output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0]  grant_dep_mask,
  output logic [B_MASK_WIDTH-1:0]                      b_mask_out,
  input  logic                                         resolve_valid,
  input  logic [B_MASK_WIDTH-1:0]                      resolve_bmm,
  input  logic                                         resolve_mispred,
  output logic [B_MASK_WIDTH-1:0]                      squash_mask,
  output logic [$clog2(B_MASK_WIDTH+1)-1:0]            free_count,
  output logic                                         stall
`ifdef BMASK_ALLOC_PERF_EN
  ,
  output logic [31:0]                                  perf_stall_cycles,
  output logic [31:0]                                  perf_squash_count
`endif
);

  import branch_mask_allocator_pkg::*;

  localparam int FREE_W = $clog2(B_MASK_WIDTH + 1);
  localparam int SLOT_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  logic [B_MASK_WIDTH-1:0] live_q;
  logic [B_MASK_WIDTH-1:0] dep_q    [B_MASK_WIDTH];
  logic [B_MASK_WIDTH-1:0] dep_next [B_MASK_WIDTH];
  logic [FREE_W-1:0]       free_count_q;
  logic [FREE_W-1:0]       free_next;
  logic [FREE_W-1:0]       live_cnt;
  logic [B_MASK_WIDTH-1:0] live_next;

  logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0] pick_onehot;
  logic [DISPATCH_WIDTH-1:0]                   pick_found;

  logic                    resolve_onehot;
  logic                    resolve_hit;
  logic                    mispred_hit;
  logic [B_MASK_WIDTH-1:0] correct_clr;
  logic [B_MASK_WIDTH-1:0] clr_mask;
  logic [B_MASK_WIDTH-1:0] grant_acc;
  logic [B_MASK_WIDTH-1:0] granted_bits;
  logic [SLOT_W-1:0]       pick_idx;
  logic                    slot_blocked;

  // Bits freed by a correct resolve this cycle are still live here, so they
  // cannot be handed out until the following cycle.
  bmask_free_picker #(
    .NUM_BITS  (B_MASK_WIDTH),
    .NUM_PICKS (DISPATCH_WIDTH)
  ) u_free_picker (
    .free_bits   (~live_q),
    .pick_onehot (pick_onehot),
    .pick_found  (pick_found)
  );

  // Resolve qualification: a non-one-hot or non-live resolve is ignored.
  always_comb begin
    resolve_onehot = (resolve_bmm != '0) &&
                     ((resolve_bmm & (resolve_bmm - 1'b1)) == '0);
    resolve_hit    = resolve_valid && resolve_onehot && ((resolve_bmm & live_q) != '0);
    mispred_hit    = resolve_hit && resolve_mispred;
    correct_clr    = (resolve_hit && !resolve_mispred) ? resolve_bmm : '0;
  end

  // Squash set: the mispredicted bit plus every live entry that depends on it.
  always_comb begin
    squash_mask = '0;
    if (mispred_hit) begin
      squash_mask = resolve_bmm;
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
        if (live_q[i] && ((dep_q[i] & resolve_bmm) != '0)) squash_mask[i] = 1'b1;
      end
    end
  end

  // In-order slot grant: a refused requesting slot blocks every younger slot.
  always_comb begin
    dispatch_grant = '0;
    grant_bmm      = '0;
    grant_dep_mask = '0;
    grant_acc      = live_q & ~correct_clr;
    pick_idx       = '0;
    slot_blocked   = 1'b0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      grant_dep_mask[k] = grant_acc;
      if (dispatch_req[k]) begin
        if (!slot_blocked && reset && !mispred_hit && pick_found[pick_idx]) begin
          dispatch_grant[k] = 1'b1;
          grant_bmm[k]      = pick_onehot[pick_idx];
          grant_acc         = grant_acc | pick_onehot[pick_idx];
          pick_idx          = pick_idx + 1'b1;
        end else begin
          slot_blocked = 1'b1;
        end
      end
    end
  end

  // Next live set, dependency rows and free count.
  always_comb begin
    clr_mask     = correct_clr | squash_mask;
    granted_bits = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) granted_bits = granted_bits | grant_bmm[k];
    live_next = (live_q & ~clr_mask) | granted_bits;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      dep_next[i] = clr_mask[i] ? '0 : (dep_q[i] & ~clr_mask);
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (grant_bmm[k][i]) dep_next[i] = grant_dep_mask[k];
      end
    end
    live_cnt = '0;
    for (int i = 0; i < B_MASK_WIDTH; i++) live_cnt = live_cnt + FREE_W'(live_next[i]);
    free_next = FREE_W'(B_MASK_WIDTH) - live_cnt;
  end

  // Allocator state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_q       <= '0;
      free_count_q <= FREE_W'(B_MASK_WIDTH);
      for (int i = 0; i < B_MASK_WIDTH; i++) dep_q[i] <= '0;
    end else begin
      live_q       <= live_next;
      free_count_q <= free_next;
      for (int i = 0; i < B_MASK_WIDTH; i++) dep_q[i] <= dep_next[i];
    end
  end

  assign b_mask_out = live_q;
  assign free_count = free_count_q;
  assign stall      = |(dispatch_req & ~dispatch_grant);

`ifdef BMASK_ALLOC_PERF_EN
  // Saturating stall-cycle and mispredict counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_squash_count <= '0;
    end else begin
      if (stall && (perf_stall_cycles != {BMASK_PERF_W{1'b1}}))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (mispred_hit && (perf_squash_count != {BMASK_PERF_W{1'b1}}))
        perf_squash_count <= perf_squash_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_mask_allocator.sv
// Self-checking bench for branch_mask_allocator. The reference model keeps
// outstanding branches as an age-ordered queue: dependencies of an entry are
// everything older in the queue, and a mispredict drops its tail.
module tb_branch_mask_allocator;

  localparam int B = 4;
  localparam int D = 2;

  logic               clock;
  logic               reset;
  logic [D-1:0]       dispatch_req;
  logic [D-1:0]       dispatch_grant;
  logic [D-1:0][B-1:0] grant_bmm;
  logic [D-1:0][B-1:0] grant_dep_mask;
  logic [B-1:0]       b_mask_out;
  logic               resolve_valid;
  logic [B-1:0]       resolve_bmm;
  logic               resolve_mispred;
  logic [B-1:0]       squash_mask;
  logic [2:0]         free_count;
  logic               stall;
`ifdef BMASK_ALLOC_PERF_EN
  logic [31:0]        perf_stall_cycles;
  logic [31:0]        perf_squash_count;
`endif

  branch_mask_allocator #(.B_MASK_WIDTH(B), .DISPATCH_WIDTH(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .dispatch_req    (dispatch_req),
    .dispatch_grant  (dispatch_grant),
    .grant_bmm       (grant_bmm),
    .grant_dep_mask  (grant_dep_mask),
    .b_mask_out      (b_mask_out),
    .resolve_valid   (resolve_valid),
    .resolve_bmm     (resolve_bmm),
    .resolve_mispred (resolve_mispred),
    .squash_mask     (squash_mask),
    .free_count      (free_count),
    .stall           (stall)
`ifdef BMASK_ALLOC_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_squash_count (perf_squash_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [B-1:0] age_q [$];
  int unsigned  m_stall_cnt;
  int unsigned  m_squash_cnt;

  logic [D-1:0] obs_grant;
  logic [B-1:0] obs_bmm0, obs_bmm1, obs_dep0, obs_dep1, obs_sq, obs_bmask;
  logic [2:0]   obs_free;
  logic         obs_stall;
  logic [31:0]  obs_pstall, obs_psq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset           = 1'b0;
    dispatch_req    = '0;
    resolve_valid   = 1'b0;
    resolve_bmm     = '0;
    resolve_mispred = 1'b0;
    age_q.delete();
    m_stall_cnt  = 0;
    m_squash_cnt = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic do_cycle(input logic [D-1:0] req, input logic rv,
                          input logic [B-1:0] rb, input logic rm);
    logic [B-1:0] live_m, base, taken, exp_sq;
    logic [D-1:0] exp_grant;
    logic [B-1:0] exp_bmm [D];
    logic [B-1:0] exp_dep [D];
    logic [B-1:0] free_list [$];
    logic         hit, mis, cor, blocked, exp_stall;
    int           pos, nxt;

    @(negedge clock);
    dispatch_req    = req;
    resolve_valid   = rv;
    resolve_bmm     = rb;
    resolve_mispred = rm;
    #1;

    live_m = '0;
    pos    = -1;
    for (int i = 0; i < age_q.size(); i++) begin
      live_m |= age_q[i];
      if (age_q[i] == rb) pos = i;
    end
    hit = rv && ($countones(rb) == 1) && (pos >= 0);
    mis = hit && rm;
    cor = hit && !rm;
    exp_sq = '0;
    if (mis) for (int i = pos; i < age_q.size(); i++) exp_sq |= age_q[i];
    for (int b = 0; b < B; b++) if (!live_m[b]) free_list.push_back(B'(1) << b);
    base    = cor ? (live_m & ~rb) : live_m;
    taken   = '0;
    blocked = 1'b0;
    nxt     = 0;
    exp_grant = '0;
    for (int k = 0; k < D; k++) begin
      exp_dep[k] = base | taken;
      exp_bmm[k] = '0;
      if (req[k]) begin
        if (!blocked && !mis && nxt < free_list.size()) begin
          exp_grant[k] = 1'b1;
          exp_bmm[k]   = free_list[nxt];
          taken       |= free_list[nxt];
          nxt++;
        end else begin
          blocked = 1'b1;
        end
      end
    end
    exp_stall = |(req & ~exp_grant);

    obs_grant = dispatch_grant;
    obs_bmm0  = grant_bmm[0];
    obs_bmm1  = grant_bmm[1];
    obs_dep0  = grant_dep_mask[0];
    obs_dep1  = grant_dep_mask[1];
    obs_sq    = squash_mask;
    obs_bmask = b_mask_out;
    obs_free  = free_count;
    obs_stall = stall;

    chk("grant",  dispatch_grant,    exp_grant);
    chk("bmm0",   grant_bmm[0],      exp_bmm[0]);
    chk("bmm1",   grant_bmm[1],      exp_bmm[1]);
    chk("dep0",   grant_dep_mask[0], exp_dep[0]);
    chk("dep1",   grant_dep_mask[1], exp_dep[1]);
    chk("squash", squash_mask,       exp_sq);
    chk("stall",  stall,             exp_stall);
    chk("b_mask", b_mask_out,        live_m);
    chk("free",   free_count,        B - $countones(live_m));
`ifdef BMASK_ALLOC_PERF_EN
    obs_pstall = perf_stall_cycles;
    obs_psq    = perf_squash_count;
    chk("perf_stall",  perf_stall_cycles, m_stall_cnt);
    chk("perf_squash", perf_squash_count, m_squash_cnt);
`endif

    @(posedge clock);
    if (cor) age_q.delete(pos);
    if (mis) while (age_q.size() > pos) void'(age_q.pop_back());
    for (int k = 0; k < D; k++) if (exp_grant[k]) age_q.push_back(exp_bmm[k]);
    if (exp_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (mis && m_squash_cnt != 32'hFFFF_FFFF) m_squash_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [B-1:0] rb;
    int sel;

    reset           = 1'b0;
    dispatch_req    = 2'b11;
    resolve_valid   = 1'b1;
    resolve_bmm     = 4'b0001;
    resolve_mispred = 1'b1;
    obs_pstall      = '0;
    obs_psq         = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_grant",  dispatch_grant, 2'b00);
    chk("rst_bmm0",   grant_bmm[0],   4'b0000);
    chk("rst_squash", squash_mask,    4'b0000);
    chk("rst_bmask",  b_mask_out,     4'b0000);
    chk("rst_free",   free_count,     3'd4);

    // First allocation after reset.
    apply_reset();
    do_cycle(2'b11, 1'b0, 4'b0000, 1'b0);
    chk("s1_grant", obs_grant, 2'b11);
    chk("s1_bmm0",  obs_bmm0,  4'b0001);
    chk("s1_bmm1",  obs_bmm1,  4'b0010);
    chk("s1_dep1",  obs_dep1,  4'b0001);
    do_cycle(2'b00, 1'b0, 4'b0000, 1'b0);
    chk("s1_bmask", obs_bmask, 4'b0011);
    chk("s1_free",  obs_free,  3'd2);

    // Fill to full.
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b11, 1'b0, 4'b0000, 1'b0);
    chk("s2_grant", obs_grant, 2'b01);
    chk("s2_bmm0",  obs_bmm0,  4'b1000);
    chk("s2_stall", obs_stall, 1'b1);
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    chk("s2_full_grant", obs_grant, 2'b00);
    chk("s2_full_free",  obs_free,  3'd0);

    // Correct resolve frees a bit one cycle late and clears dependents.
    apply_reset();
    do_cycle(2'b11, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b00, 1'b1, 4'b0001, 1'b0);
    chk("s3_squash", obs_sq, 4'b0000);
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    chk("s3_bmask", obs_bmask, 4'b0010);
    chk("s3_regrant", obs_bmm0, 4'b0001);
    do_cycle(2'b00, 1'b1, 4'b0001, 1'b1);
    chk("s3_squash_young", obs_sq, 4'b0001);

    // Chained dependents squashed on mispredict.
    apply_reset();
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    chk("s4_bmm0", obs_bmm0, 4'b0100);
    chk("s4_dep0", obs_dep0, 4'b0011);
    do_cycle(2'b11, 1'b1, 4'b0010, 1'b1);
    chk("s4_squash", obs_sq,    4'b0110);
    chk("s4_grant",  obs_grant, 2'b00);
    do_cycle(2'b00, 1'b0, 4'b0000, 1'b0);
    chk("s4_bmask", obs_bmask, 4'b0001);

    // Ignored resolves: non-live bit and non-one-hot.
    do_cycle(2'b00, 1'b1, 4'b1000, 1'b1);
    chk("s5_squash", obs_sq, 4'b0000);
    do_cycle(2'b00, 1'b1, 4'b0011, 1'b1);
    chk("s5_squash_multi", obs_sq, 4'b0000);
    do_cycle(2'b00, 1'b0, 4'b0000, 1'b0);
    chk("s5_bmask", obs_bmask, 4'b0001);
    chk("s5_free",  obs_free,  3'd3);

    // Asynchronous reset in the middle of a granting cycle.
    @(negedge clock);
    dispatch_req = 2'b11;
    #1;
    chk("mid_pre_grant", dispatch_grant, 2'b11);
    reset = 1'b0;
    #1;
    chk("mid_grant", dispatch_grant, 2'b00);
    chk("mid_bmask", b_mask_out,     4'b0000);
    chk("mid_free",  free_count,     3'd4);
    resolve_valid   = 1'b1;
    resolve_bmm     = 4'b0001;
    resolve_mispred = 1'b1;
    #1;
    chk("mid_squash", squash_mask, 4'b0000);
    apply_reset();

`ifdef BMASK_ALLOC_PERF_EN
    do_cycle(2'b11, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b11, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b01, 1'b0, 4'b0000, 1'b0);
    do_cycle(2'b00, 1'b1, 4'b0001, 1'b1);
    do_cycle(2'b00, 1'b0, 4'b0000, 1'b0);
    chk("perf_stall_total",  obs_pstall, 32'd3);
    chk("perf_squash_total", obs_psq,    32'd1);
    apply_reset();
`endif

    // Randomized traffic against the age-queue model.
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7 && age_q.size() > 0)
        rb = age_q[$urandom_range(0, age_q.size() - 1)];
      else if (sel < 9)
        rb = B'(1) << $urandom_range(0, B - 1);
      else
        rb = B'($urandom);
      do_cycle(D'($urandom), ($urandom_range(0, 1) == 1), rb,
               ($urandom_range(0, 9) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
